bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the 8-digit seven-segment display driver. Its held 32-bit packed-BCD output drives the driver's 32-bit digit input, one nibble per digit, with digit 0 at bits [3:0]. The output register changes only on completed conversions, so the display never shows partial values.

---
 rtl/bin2bcd_seq_if.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the bin2bcd_seq converter.
// When HEX_BYPASS_EN is defined the bundle also carries hex_mode.
interface bin2bcd_seq_if #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 8
);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic             start;
    logic [IN_W-1:0]  bin_in;
`ifdef HEX_BYPASS_EN
    logic             hex_mode;
`endif
    logic             busy;
    logic             done;
    logic             ovf;
    logic [BCD_W-1:0] bcd_out;

    // Source side: issues requests, observes results.
    modport master (
        output start,
        output bin_in,
`ifdef HEX_BYPASS_EN
        output hex_mode,
`endif
        input  busy,
        input  done,
        input  ovf,
        input  bcd_out
    );

    // Converter side.
    modport slave (
        input  start,
        input  bin_in,
`ifdef HEX_BYPASS_EN
        input  hex_mode,
`endif
        output busy,
        output done,
        output ovf,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), one input bit per clock.
// Feeds the 8-digit seven-segment driver; bcd_out only changes on a finished
// conversion so the display never shows partial values.
// Optional feature macro: HEX_BYPASS_EN adds hex_mode, which passes bin_in
// straight to bcd_out so the display shows raw hex.
module bin2bcd_seq #(
    parameter int unsigned     IN_W    = 32,
    parameter int unsigned     DIGITS  = 8,
    parameter longint unsigned MAX_VAL = 64'd99999999
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam logic [BCD_W-1:0] OVF_PATTERN = {DIGITS{4'hE}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   shift_q;
    logic [BCD_W-1:0]  scratch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [BCD_W-1:0]  bcd_q;

    logic [BCD_W-1:0]       adj_c;
    logic [BCD_W+IN_W-1:0]  shifted_c;
    logic [BCD_W-1:0]       scratch_nxt_c;
    logic [IN_W-1:0]        shift_nxt_c;
    logic                   in_ovf_c;
    logic                   last_iter_c;
    logic                   hex_c;

    // One double-dabble step: add 3 to every digit >= 5, then shift the pair left.
    always_comb begin
        adj_c = scratch_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adj_c[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
        shifted_c     = {adj_c, shift_q} << 1;
        scratch_nxt_c = shifted_c[BCD_W+IN_W-1 -: BCD_W];
        shift_nxt_c   = shifted_c[IN_W-1:0];
    end

    // Request qualifiers decoded from the bus.
    always_comb begin
        in_ovf_c    = (bus.bin_in > IN_W'(MAX_VAL));
        last_iter_c = (cnt_q == CNT_W'(IN_W - 1));
`ifdef HEX_BYPASS_EN
        hex_c       = bus.hex_mode;
`else
        hex_c       = 1'b0;
`endif
    end

    // Control FSM plus datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        shift_q   <= bus.bin_in;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        if (hex_c) begin
                            // Raw pass-through, no decimal conversion.
                            state  <= FIN;
                            done_q <= 1'b1;
                            ovf_q  <= 1'b0;
                            bcd_q  <= BCD_W'(bus.bin_in);
                        end else if (in_ovf_c) begin
                            // Value does not fit in DIGITS decimal digits.
                            state  <= FIN;
                            done_q <= 1'b1;
                            ovf_q  <= 1'b1;
                            bcd_q  <= OVF_PATTERN;
                        end else begin
                            state  <= CONV;
                            busy_q <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    scratch_q <= scratch_nxt_c;
                    shift_q   <= shift_nxt_c;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (last_iter_c) begin
                        // Publish the final scratch value on the same edge as done.
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ovf_q  <= 1'b0;
                        bcd_q  <= scratch_nxt_c;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values,
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;

    bin2bcd_seq_if #(.IN_W(32), .DIGITS(8)) ifc ();

    bin2bcd_seq #(.IN_W(32), .DIGITS(8), .MAX_VAL(64'd99999999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, bcd} from plain decimal arithmetic.
    function automatic logic [32:0] ref_model(input logic [31:0] v, input bit hex);
        logic [31:0] r;
        longint unsigned x;
        r = '0;
        if (hex) return {1'b0, v};
        if (v > 32'd99999999) return {1'b1, 32'hEEEE_EEEE};
        x = longint'(v);
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hex(input bit h);
`ifdef HEX_BYPASS_EN
        ifc.hex_mode = h;
`else
        if (h) $display("hex request ignored in decimal-only build");
`endif
    endtask

    // Present a request for one cycle; returns after the accepting edge.
    task automatic issue(input logic [31:0] v, input bit h);
        ifc.start  = 1'b1;
        ifc.bin_in = v;
        set_hex(h);
        tick();
        ifc.start  = 1'b0;
        set_hex(1'b0);
    endtask

    // Wait for done; reports cycles since the request, busy cycles and whether
    // bcd_out stayed at prev_out until done. Optionally pokes start mid-way.
    task automatic wait_done(input logic [31:0] prev_out, input int poke_at,
                             input logic [31:0] poke_val,
                             output int cycles, output int busy_cnt, output bit held);
        cycles   = 1;
        busy_cnt = 0;
        held     = 1'b1;
        while (!ifc.done && cycles < 64) begin
            if (ifc.busy) busy_cnt++;
            if (ifc.bcd_out !== prev_out) held = 1'b0;
            if (cycles == poke_at) begin
                ifc.start  = 1'b1;
                ifc.bin_in = poke_val;
            end else begin
                ifc.start  = 1'b0;
            end
            tick();
            cycles++;
        end
        ifc.start = 1'b0;
    endtask

    // Full conversion with checks on result, overflow flag and latency.
    task automatic run_one(input string tag, input logic [31:0] v, input bit h);
        logic [32:0] exp;
        logic [31:0] prev;
        int cyc, bc;
        bit held;
        exp  = ref_model(v, h);
        prev = ifc.bcd_out;
        issue(v, h);
        wait_done(prev, 0, '0, cyc, bc, held);
        check({tag, " bcd"}, ifc.bcd_out, exp[31:0]);
        check({tag, " ovf"}, 32'(ifc.ovf), 32'(exp[32]));
        check({tag, " lat"}, 32'(cyc), (exp[32] || h) ? 32'd1 : 32'd33);
        tick();
        check({tag, " done pulse"}, 32'(ifc.done), 32'd0);
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] v;
        int cyc, bc;
        bit held;
        bit saw_done;

        rst_n      = 1'b0;
        ifc.start  = 1'b0;
        ifc.bin_in = '0;
        set_hex(1'b0);
        tick();
        tick();
        check("rst busy", 32'(ifc.busy), 32'd0);
        check("rst done", 32'(ifc.done), 32'd0);
        check("rst ovf",  32'(ifc.ovf),  32'd0);
        check("rst bcd",  ifc.bcd_out,   32'd0);
        rst_n = 1'b1;
        tick();

        // Zero: latency and busy width.
        issue(32'd0, 1'b0);
        wait_done(32'd0, 0, '0, cyc, bc, held);
        check("zero bcd",  ifc.bcd_out, 32'h0000_0000);
        check("zero ovf",  32'(ifc.ovf), 32'd0);
        check("zero lat",  32'(cyc), 32'd33);
        check("zero busy", 32'(bc),  32'd32);
        tick();

        // Output must hold the old value until done.
        issue(32'd12345678, 1'b0);
        wait_done(32'd0, 0, '0, cyc, bc, held);
        check("12345678 held", 32'(held), 32'd1);
        check("12345678 bcd",  ifc.bcd_out, 32'h1234_5678);
        tick();

        run_one("max", 32'd99999999, 1'b0);
        run_one("max+1", 32'd100000000, 1'b0);

        // Start during CONV is ignored; start in FIN is accepted.
        issue(32'd255, 1'b0);
        wait_done(32'hEEEE_EEEE, 10, 32'd7, cyc, bc, held);
        check("255 bcd", ifc.bcd_out, 32'h0000_0255);
        check("255 lat", 32'(cyc), 32'd33);
        issue(32'd42, 1'b0);
        wait_done(32'h0000_0255, 0, '0, cyc, bc, held);
        check("b2b bcd", ifc.bcd_out, 32'h0000_0042);
        check("b2b lat", 32'(cyc), 32'd33);
        tick();

        // Reset mid-conversion aborts without a done pulse.
        issue(32'd31337, 1'b0);
        saw_done = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (ifc.done) saw_done = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 32'(ifc.busy), 32'd0);
        check("abort bcd",  ifc.bcd_out,   32'd0);
        check("abort ovf",  32'(ifc.ovf),  32'd0);
        for (int i = 0; i < 40; i++) begin
            if (ifc.done) saw_done = 1'b1;
            tick();
        end
        check("abort no done", 32'(saw_done), 32'd0);
        run_one("all ones", 32'hFFFF_FFFF, 1'b0);

        // Random values, biased toward the representable range.
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 3) v = $urandom();
            else if (k % 4 == 2) v = 32'($urandom_range(99999999, 99999000));
            else v = 32'($urandom_range(99999999, 0));
            run_one($sformatf("rnd%0d", k), v, 1'b0);
        end

`ifdef HEX_BYPASS_EN
        run_one("hex", 32'hDEAD_BEEF, 1'b1);
        run_one("hex small", 32'h0000_00A5, 1'b1);
        run_one("dec after hex", 32'd87654321, 1'b0);
`endif

        exp = ref_model(32'd0, 1'b0);
        if (exp[32]) $display("reference model inconsistent");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the run gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
